// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit FIFO slice.
//   DEFAULT_DEPTH : default FIFO capacity in bytes
//   tx_state_e    : handshake FSM state encoding
package uart_pkg;

  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular byte buffer with registered status flags.
// Ports:
//   clk, nrst   : clock, asynchronous active-low reset
//   push        : enqueue wr_data (ignored while full)
//   wr_data     : byte to enqueue
//   pop         : dequeue the head byte (ignored while empty)
//   rd_data     : head byte, valid whenever empty=0
//   full, empty : registered occupancy flags
//   level       : registered occupancy count, 0..DEPTH
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          push,
  input  logic [7:0]    wr_data,
  input  logic          pop,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          push_ok;
  logic          pop_ok;

  // A push while full is rejected even if a pop happens in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok)
      count_next = count + 1'b1;
    else if (!push_ok && pop_ok)
      count_next = count - 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
    end
  end

  // Storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign level   = count;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter through a
// valid/ack handshake, with sticky overflow reporting.
// Ports:
//   clk, nrst : clock, asynchronous active-low reset
//   wr_data   : byte to enqueue
//   wr_en     : enqueue strobe, one byte per cycle
//   full      : FIFO holds DEPTH bytes
//   empty     : FIFO holds 0 bytes
//   level     : bytes stored, 0..DEPTH
//   overflow  : sticky, set by a write attempted while full
//   ovf_clr   : clears overflow (a same-cycle overflow wins)
//   tx_data   : byte presented to the transmitter (registered)
//   tx_valid  : byte-valid level to the transmitter (registered)
//   tx_ack    : transmitter frame-done acknowledge
//   busy      : FSM not idle or FIFO not empty
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | tx_valid low; pops the head byte once not empty and ack low
// ST_SEND    | tx_valid high, tx_data stable; waits for tx_ack high
// ST_RELEASE | tx_valid low; waits for tx_ack to drop
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  wr_data,
  input  logic        wr_en,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level,
  output logic        overflow,
  input  logic        ovf_clr,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ack,
  output logic        busy
);

  tx_state_e  state;
  logic [7:0] head;
  logic       pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .push    (wr_en),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // A stale ack left high from the previous frame holds the FSM in IDLE.
  assign pop = (state == ST_IDLE) && !empty && !tx_ack;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      overflow <= 1'b0;
    else if (wr_en && full)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            tx_data  <= head;
            tx_valid <= 1'b1;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_ack) begin
            tx_valid <= 1'b0;
            state    <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!tx_ack)
            state <= ST_IDLE;
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  logic       clk;
  logic       nrst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       ovf_clr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ack;
  logic       busy;

  int total;
  int bad;
  int max_level;
  logic [7:0] wq[$];
  logic [7:0] rq[$];
  logic [7:0] eq[$];

  uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ack   (tx_ack),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writer plus ack model: writes queued bytes whenever not full, raises
  // tx_ack ack_dly cycles after each tx_valid rise, drops it one cycle
  // after tx_valid falls, and records every presented byte.
  task automatic run_stream(input int ack_dly, input int n_exp, input int budget);
    int  cnt;
    int  cyc;
    bit  prev_v;
    bit  drop;
    cnt = 0; cyc = 0; prev_v = 0; drop = 0;
    max_level = 0;
    rq.delete();
    while (cyc < budget &&
           !(rq.size() == n_exp && wq.size() == 0 && !tx_valid && !tx_ack)) begin
      if (drop) begin
        tx_ack = 1'b0;
        drop = 0;
      end
      if (tx_valid && !prev_v) begin
        rq.push_back(tx_data);
        cnt = 0;
      end
      if (tx_valid) begin
        cnt++;
        if (cnt == ack_dly) tx_ack = 1'b1;
      end
      if (!tx_valid && prev_v) drop = 1;
      prev_v = tx_valid;
      if (int'(level) > max_level) max_level = int'(level);
      if (wq.size() > 0 && !full) begin
        wr_en   = 1'b1;
        wr_data = wq.pop_front();
      end else begin
        wr_en = 1'b0;
      end
      tick();
      cyc++;
    end
    wr_en = 1'b0;
    chk("stream_in_budget", cyc < budget, 1);
  endtask

  task automatic chk_order(input string tag);
    chk({tag, "_count"}, rq.size(), eq.size());
    for (int i = 0; i < eq.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), (i < rq.size()) ? rq[i] : 32'hFFFF_FFFF, eq[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int seen;
    total = 0; bad = 0;
    nrst = 1'b0; wr_data = 8'h00; wr_en = 1'b0; ovf_clr = 1'b0; tx_ack = 1'b0;
    tick(); tick();

    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 0);
    nrst = 1'b1;
    tick(); tick();

    // Single byte
    wr_data = 8'hA5; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("single_lat1_valid", tx_valid, 0);
    chk("single_lat1_level", level, 1);
    tick();
    chk("single_valid", tx_valid, 1);
    chk("single_data", tx_data, 8'hA5);
    chk("single_busy", busy, 1);
    chk("single_empty", empty, 1);
    tx_ack = 1'b1;
    tick();
    chk("single_fall", tx_valid, 0);
    tick();
    chk("single_low2", tx_valid, 0);
    tick();
    tx_ack = 1'b0;
    tick();
    chk("single_low4", tx_valid, 0);
    tick();
    chk("single_low5", tx_valid, 0);
    chk("single_end_empty", empty, 1);
    chk("single_end_busy", busy, 0);

    // Stale ack held while a byte arrives
    tx_ack = 1'b1;
    wr_data = 8'h3C; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (tx_valid) seen++;
    end
    chk("stale_no_valid", seen, 0);
    chk("stale_level", level, 1);
    tx_ack = 1'b0;
    tick();
    chk("stale_valid", tx_valid, 1);
    chk("stale_data", tx_data, 8'h3C);
    chk("stale_level0", level, 0);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    tick(); tick();

    // Burst with slow ack model
    wq.delete(); eq.delete();
    for (int i = 1; i <= 5; i++) begin
      wq.push_back(8'(i));
      eq.push_back(8'(i));
    end
    run_stream(10, 5, 2000);
    chk_order("burst");
    chk("burst_empty", empty, 1);

    // Full / overflow with ack held low
    for (int i = 0; i < 18; i++) begin
      wr_data = 8'(8'h10 + i); wr_en = 1'b1;
      tick();
      if (i == 16) begin
        chk("ovf_before", overflow, 0);
        chk("full_at17", full, 1);
      end
    end
    wr_en = 1'b0;
    chk("ovf_level", level, 16);
    chk("ovf_full", full, 1);
    chk("ovf_set", overflow, 1);
    chk("ovf_send_valid", tx_valid, 1);
    chk("ovf_send_data", tx_data, 8'h10);
    wr_data = 8'hEE; wr_en = 1'b1; ovf_clr = 1'b1;
    tick();
    chk("ovf_priority", overflow, 1);
    chk("ovf_reject_level", level, 16);
    wr_en = 1'b0;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
    wq.delete(); eq.delete();
    for (int i = 0; i < 17; i++) eq.push_back(8'(8'h10 + i));
    run_stream(3, 17, 3000);
    chk_order("drain");
    chk("drain_level", level, 0);

    // Wrap: 40 bytes with concurrent writes and pops
    wq.delete(); eq.delete();
    for (int i = 0; i < 40; i++) begin
      wq.push_back(8'(i * 7 + 3));
      eq.push_back(8'(i * 7 + 3));
    end
    run_stream(2, 40, 4000);
    chk_order("wrap");
    chk("wrap_max_level", max_level, 16);
    chk("wrap_no_ovf", overflow, 0);

    // Reset in SEND with 3 bytes queued
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'(8'hAA + 8'h11 * i); wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    chk("mid_valid", tx_valid, 1);
    chk("mid_data", tx_data, 8'hAA);
    chk("mid_level", level, 3);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_data", tx_data, 8'h00);
    #2 nrst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (tx_valid) seen++;
    end
    chk("post_rst_quiet", seen, 0);
    chk("post_rst_busy", busy, 0);
    wr_data = 8'h77; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
    chk("post_rst_valid", tx_valid, 1);
    chk("post_rst_data", tx_data, 8'h77);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    tick(); tick();
    chk("final_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameters SHALL be: DEPTH, 16, FIFO capacity in bytes (power of two, 2..256); AW, $clog2(DEPTH), address width.
REQ-002 Ports SHALL be:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- wr_data  in  8  byte to enqueue
- wr_en  in  1  enqueue strobe, one byte per clk cycle while high
- full  out  1  FIFO holds DEPTH bytes
- empty  out  1  FIFO holds 0 bytes
- level  out  AW+1  bytes currently stored, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full
- ovf_clr  in  1  clears overflow
- tx_data  out  8  byte presented to the UART transmitter
- tx_valid  out  1  byte-valid level to the transmitter
- tx_ack  in  1  transmitter frame-done acknowledge
- busy  out  1  high when not IDLE or not empty

Function
REQ-003 Storage SHALL be a circular buffer with AW-bit read/write pointers that wrap from DEPTH-1 to 0, plus an (AW+1)-bit occupancy count.
REQ-004 A write with wr_en=1 and full=0 SHALL store wr_data and increment the count at the next clk edge.
REQ-005 A write with full=1 SHALL be discarded, with no pointer or count change, and SHALL set overflow the next cycle.
REQ-006 ovf_clr=1 SHALL clear overflow; a simultaneous overflow event SHALL take priority and leave it set.
REQ-007 full, empty and level SHALL be registered and SHALL reflect the count after each edge.
REQ-008 A simultaneous write and pop in one cycle SHALL leave the count unchanged; a write while full is rejected even if a pop occurs that cycle.
REQ-009 The handshake FSM SHALL have three states: IDLE, SEND and RELEASE.
REQ-010 IDLE: tx_valid=0; if empty=0, load the head byte into the tx_data register, pop it, and go to SEND.
REQ-011 SEND: tx_valid=1 and tx_data held stable; on tx_ack=1, go to RELEASE.
REQ-012 RELEASE: tx_valid=0; on tx_ack=0, go to IDLE.
REQ-013 tx_valid SHALL be low for at least two consecutive clk cycles between bytes (RELEASE plus IDLE), so every byte produces a fresh rising edge of tx_valid.
REQ-014 tx_valid and tx_data SHALL be driven directly from registers, with no combinational path from any input.
REQ-015 Latency from a write into an empty IDLE FIFO to tx_valid=1 SHALL be 2 cycles: the count updates, then IDLE loads.
REQ-016 tx_ack=1 observed in IDLE SHALL be ignored, and the FSM SHALL NOT leave IDLE until tx_ack=0.
REQ-017 Bytes SHALL be presented in write order with none dropped or duplicated, including across pointer wrap.

Reset
REQ-018 nrst=0 SHALL asynchronously force:
- pointers=0, count=0, empty=1, full=0, level=0
- overflow=0, tx_valid=0, tx_data=8'h00
- state=IDLE, busy=0
REQ-019 Reset asserted mid-frame SHALL discard all stored bytes and the byte in SEND; after release, no byte is presented until a new write.
REQ-020 Memory contents SHALL NOT require reset.

Structure
REQ-021 The state enum (IDLE, SEND, RELEASE) and the default DEPTH constant SHALL live in the shared package uart_pkg.
REQ-022 Buffer storage and pointer logic SHALL be the sub-module sync_fifo (parameterised DEPTH, 8-bit data, push/pop, full/empty/level); uart_tx_fifo adds overflow tracking and the FSM.

Verification
REQ-023 Single byte: write 8'hA5 into the empty FIFO -> tx_valid rises 2 cycles later with tx_data=8'hA5; tx_ack pulse held 3 cycles -> tx_valid falls the cycle after tx_ack rises and stays low for at least 2 cycles; empty=1.
REQ-024 Burst: write 8'h01..8'h05 back-to-back, with a bench ack model asserting tx_ack 10 cycles after each tx_valid rise and dropping it 1 cycle after tx_valid falls -> exactly 5 presentations, in order 01..05.
REQ-025 Full/overflow: with DEPTH=16 and tx_ack held 0, write 18 bytes -> the first byte moves to the SEND register, so 17 are accepted; level=16, full=1, overflow=1; ovf_clr -> overflow=0.
REQ-026 Wrap: 40 bytes streamed with concurrent writes and pops -> output sequence equals input sequence, level never exceeds 16.
REQ-027 Reset mid-frame: nrst pulsed while in SEND with 3 bytes queued -> tx_valid=0, level=0, empty=1 immediately; no tx_valid after release until a new write.
REQ-028 Stale ack: tx_ack held 1 while the FIFO is loaded in IDLE -> tx_valid stays 0 until tx_ack=0, then follows REQ-010.
